// File: rtl/fetch_pkg.sv
// Shared fetch front-end types and defaults for the next-fetch-PC generator.
// Optional perf counters in fetch_pc_gen are enabled by FETCH_PC_GEN_PERF_EN.
package fetch_pkg;

  localparam int DEFAULT_XLEN        = 32;
  localparam int DEFAULT_FETCH_WIDTH = 2;
  localparam int DEFAULT_INST_BYTES  = 4;

  // Per-slot prediction bundle as delivered by the BTB/RAS lookup.
  typedef struct packed {
    logic                    btb_hit;
    logic                    is_branch;
    logic                    is_ret;
    logic                    pred_taken;
    logic [DEFAULT_XLEN-1:0] pred_target;
    logic [DEFAULT_XLEN-1:0] ret_addr;
  } fetch_slot_t;

  typedef enum logic {
    ST_RESET = 1'b0,
    ST_RUN   = 1'b1
  } fetch_state_e;

  // Slot index width; a single-slot block still gets a 1-bit index.
  function automatic int slot_idx_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/fetch_pc_gen_if.sv
// Bundle between fetch_pc_gen and its environment (redirect, BTB/RAS, fetch queue).
// Perf counter signals exist only when FETCH_PC_GEN_PERF_EN is defined.
interface fetch_pc_gen_if
  import fetch_pkg::*;
#(
  parameter int XLEN        = DEFAULT_XLEN,
  parameter int FETCH_WIDTH = DEFAULT_FETCH_WIDTH
);

  localparam int SLOT_W = slot_idx_w(FETCH_WIDTH);

  // fetch_valid/fetch_ready: a block transfers in any cycle where both are 1
  // (fire); fetch_valid and fetch_pc stay stable while stalled unless a redirect
  // arrives, and the generator never waits on fetch_ready to raise fetch_valid.
  logic                              redirect_valid;
  logic [XLEN-1:0]                   redirect_pc;
  logic [FETCH_WIDTH-1:0]            btb_hit;
  logic [FETCH_WIDTH-1:0]            is_branch;
  logic [FETCH_WIDTH-1:0]            is_ret;
  logic [FETCH_WIDTH-1:0]            pred_taken;
  logic [FETCH_WIDTH-1:0][XLEN-1:0]  pred_target;
  logic [FETCH_WIDTH-1:0][XLEN-1:0]  ret_addr;
  logic                              fetch_ready;
  logic                              fetch_valid;
  logic [XLEN-1:0]                   fetch_pc;
  logic [FETCH_WIDTH-1:0]            slot_valid;
  logic [FETCH_WIDTH-1:0][XLEN-1:0]  final_pred_target;
  logic                              taken_valid;
  logic [SLOT_W-1:0]                 taken_slot;
  fetch_state_e                      state_dbg;
`ifdef FETCH_PC_GEN_PERF_EN
  logic [31:0]                       perf_redirects;
  logic [31:0]                       perf_stalls;
  logic [31:0]                       perf_taken;

  modport master (
    input  redirect_valid, redirect_pc, btb_hit, is_branch, is_ret, pred_taken,
           pred_target, ret_addr, fetch_ready,
    output fetch_valid, fetch_pc, slot_valid, final_pred_target, taken_valid,
           taken_slot, state_dbg, perf_redirects, perf_stalls, perf_taken
  );

  modport slave (
    output redirect_valid, redirect_pc, btb_hit, is_branch, is_ret, pred_taken,
           pred_target, ret_addr, fetch_ready,
    input  fetch_valid, fetch_pc, slot_valid, final_pred_target, taken_valid,
           taken_slot, state_dbg, perf_redirects, perf_stalls, perf_taken
  );
`else
  modport master (
    input  redirect_valid, redirect_pc, btb_hit, is_branch, is_ret, pred_taken,
           pred_target, ret_addr, fetch_ready,
    output fetch_valid, fetch_pc, slot_valid, final_pred_target, taken_valid,
           taken_slot, state_dbg
  );

  modport slave (
    output redirect_valid, redirect_pc, btb_hit, is_branch, is_ret, pred_taken,
           pred_target, ret_addr, fetch_ready,
    input  fetch_valid, fetch_pc, slot_valid, final_pred_target, taken_valid,
           taken_slot, state_dbg
  );
`endif

endinterface

// File: rtl/fetch_pc_gen_taken_slot_pe.sv
// Lowest-index-first priority encoder picking the first slot that redirects fetch.
module taken_slot_pe
  import fetch_pkg::*;
#(
  parameter int WIDTH = DEFAULT_FETCH_WIDTH,
  parameter int IDX_W = slot_idx_w(WIDTH)
) (
  input  logic [WIDTH-1:0] req,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req[i]) idx = IDX_W'(i);
    end
  end

  assign valid = |req;

endmodule

// File: rtl/fetch_pc_gen.sv
// Next-fetch-PC generator: block-aligned sequential advance, BTB/RAS steering,
// backend redirect. Define FETCH_PC_GEN_PERF_EN to add saturating perf counters.
module fetch_pc_gen
  import fetch_pkg::*;
#(
  parameter int              XLEN         = DEFAULT_XLEN,
  parameter int              FETCH_WIDTH  = DEFAULT_FETCH_WIDTH,
  parameter int              INST_BYTES   = DEFAULT_INST_BYTES,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input logic            CLK,
  input logic            reset,
  fetch_pc_gen_if.master bus
);

  localparam int              SLOT_W      = slot_idx_w(FETCH_WIDTH);
  localparam int              OFF_LSB     = $clog2(INST_BYTES);
  localparam int              BLOCK_BYTES = FETCH_WIDTH * INST_BYTES;
  localparam logic [XLEN-1:0] BLOCK_MASK  = XLEN'(BLOCK_BYTES - 1);

  fetch_state_e                     state_q, state_d;
  logic [XLEN-1:0]                  pc_q, pc_d;
  logic                             fetch_valid;
  logic                             fire;
  logic [SLOT_W-1:0]                off;
  logic [XLEN-1:0]                  seq_pc;
  logic [FETCH_WIDTH-1:0]           in_block;
  logic [FETCH_WIDTH-1:0]           redir_req;
  logic [FETCH_WIDTH-1:0]           slot_valid;
  logic [FETCH_WIDTH-1:0][XLEN-1:0] final_tgt;
  logic                             taken_valid;
  logic [SLOT_W-1:0]                taken_slot;

  assign fetch_valid = (state_q == ST_RUN);
  assign fire        = fetch_valid && bus.fetch_ready;
  assign off         = SLOT_W'((pc_q >> OFF_LSB) & XLEN'(FETCH_WIDTH - 1));
  assign seq_pc      = (pc_q & ~BLOCK_MASK) + XLEN'(BLOCK_BYTES);

  // Slots before the entry offset belong to the previous path and never redirect.
  always_comb begin
    in_block  = '0;
    redir_req = '0;
    final_tgt = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      in_block[i]  = (i >= int'(off));
      redir_req[i] = fetch_valid && in_block[i] && bus.btb_hit[i] &&
                     (bus.is_ret[i] || !bus.is_branch[i] || bus.pred_taken[i]);
      final_tgt[i] = bus.is_ret[i] ? bus.ret_addr[i] : bus.pred_target[i];
    end
  end

  taken_slot_pe #(
    .WIDTH (FETCH_WIDTH),
    .IDX_W (SLOT_W)
  ) u_taken_slot_pe (
    .req   (redir_req),
    .valid (taken_valid),
    .idx   (taken_slot)
  );

  always_comb begin
    slot_valid = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      slot_valid[i] = fetch_valid && in_block[i] &&
                      (!taken_valid || (i <= int'(taken_slot)));
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      ST_RESET: state_d = ST_RUN;
      ST_RUN:   state_d = ST_RUN;
      default:  state_d = ST_RESET;
    endcase
    // Redirect beats everything; a block that fires alongside it is flushed later.
    if (bus.redirect_valid) begin
      pc_d = bus.redirect_pc;
    end else if (fire) begin
      pc_d = taken_valid ? final_tgt[taken_slot] : seq_pc;
    end
  end

  always_ff @(posedge CLK) begin
    if (!reset) begin
      state_q <= ST_RESET;
      pc_q    <= RESET_VECTOR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign bus.fetch_valid       = fetch_valid;
  assign bus.fetch_pc          = pc_q;
  assign bus.slot_valid        = slot_valid;
  assign bus.final_pred_target = final_tgt;
  assign bus.taken_valid       = taken_valid;
  assign bus.taken_slot        = taken_slot;
  assign bus.state_dbg         = state_q;

`ifdef FETCH_PC_GEN_PERF_EN
  logic [31:0] perf_redirects_q, perf_redirects_d;
  logic [31:0] perf_stalls_q, perf_stalls_d;
  logic [31:0] perf_taken_q, perf_taken_d;

  // Counters stick at all-ones instead of wrapping.
  always_comb begin
    perf_redirects_d = perf_redirects_q;
    perf_stalls_d    = perf_stalls_q;
    perf_taken_d     = perf_taken_q;
    if (bus.redirect_valid && (perf_redirects_q != '1))
      perf_redirects_d = perf_redirects_q + 32'd1;
    if (fetch_valid && !bus.fetch_ready && (perf_stalls_q != '1))
      perf_stalls_d = perf_stalls_q + 32'd1;
    if (fire && taken_valid && (perf_taken_q != '1))
      perf_taken_d = perf_taken_q + 32'd1;
  end

  always_ff @(posedge CLK) begin
    if (!reset) begin
      perf_redirects_q <= '0;
      perf_stalls_q    <= '0;
      perf_taken_q     <= '0;
    end else begin
      perf_redirects_q <= perf_redirects_d;
      perf_stalls_q    <= perf_stalls_d;
      perf_taken_q     <= perf_taken_d;
    end
  end

  assign bus.perf_redirects = perf_redirects_q;
  assign bus.perf_stalls    = perf_stalls_q;
  assign bus.perf_taken     = perf_taken_q;
`endif

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Bench for fetch_pc_gen: directed scenarios then random traffic against a
// block-level reference model. Perf checks active with FETCH_PC_GEN_PERF_EN.
`timescale 1ns/1ps
module tb_fetch_pc_gen;
  import fetch_pkg::*;

  localparam int          XLEN = 32;
  localparam int          FW   = 2;
  localparam int          IB   = 4;
  localparam logic [31:0] RV   = 32'h0;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fetch_pc_gen_if #(.XLEN(XLEN), .FETCH_WIDTH(FW)) bus ();

  fetch_pc_gen #(
    .XLEN         (XLEN),
    .FETCH_WIDTH  (FW),
    .INST_BYTES   (IB),
    .RESET_VECTOR (RV)
  ) dut (
    .CLK   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- stimulus state ----------------
  logic        rst_n_in;
  logic        rv;
  logic [31:0] rpc;
  logic        rdy;
  fetch_slot_t sl [FW];
  bit          chk_en;

  // ---------------- model / scoreboard ----------------
  logic [XLEN-1:0] exp_q [$];
  bit              m_valid;
  longint          m_perf_r, m_perf_s, m_perf_t;
  int              n_checks, n_pass;

  logic [31:0]     obs_pc;
  logic            obs_fv, obs_tv;
  logic [FW-1:0]   obs_sv;
  logic [0:0]      obs_ts;
  logic [31:0]     obs_fin [FW];
`ifdef FETCH_PC_GEN_PERF_EN
  logic [31:0]     obs_stalls, obs_redirects;
`endif

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic longint sat_inc(input longint v);
    return (v >= 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : v + 1;
  endfunction

  task automatic idle_inputs();
    rv  = 1'b0;
    rpc = 32'h0;
    rdy = 1'b1;
    for (int i = 0; i < FW; i++) sl[i] = '0;
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic run_cycle();
    logic [31:0]   cur_pc, nxt;
    longint        p, base;
    int            off, ts;
    bit            tv, fire;
    logic [FW-1:0] sv;
    logic [31:0]   fin [FW];

    @(negedge clk);
    reset              = rst_n_in;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.fetch_ready    = rdy;
    for (int i = 0; i < FW; i++) begin
      bus.btb_hit[i]     = sl[i].btb_hit;
      bus.is_branch[i]   = sl[i].is_branch;
      bus.is_ret[i]      = sl[i].is_ret;
      bus.pred_taken[i]  = sl[i].pred_taken;
      bus.pred_target[i] = sl[i].pred_target;
      bus.ret_addr[i]    = sl[i].ret_addr;
    end
    #1;

    cur_pc = exp_q.pop_front();
    p      = longint'(cur_pc);
    off    = int'((p / IB) % FW);
    base   = p - (p % (FW * IB));
    tv     = 1'b0;
    ts     = 0;
    for (int i = 0; i < FW; i++) begin
      fin[i] = sl[i].is_ret ? sl[i].ret_addr : sl[i].pred_target;
      if (m_valid && !tv && i >= off && sl[i].btb_hit &&
          (sl[i].is_ret || !sl[i].is_branch || sl[i].pred_taken)) begin
        tv = 1'b1;
        ts = i;
      end
    end
    for (int i = 0; i < FW; i++) sv[i] = m_valid && (i >= off) && (!tv || i <= ts);

    obs_pc = bus.fetch_pc;
    obs_fv = bus.fetch_valid;
    obs_sv = bus.slot_valid;
    obs_tv = bus.taken_valid;
    obs_ts = bus.taken_slot;
    for (int i = 0; i < FW; i++) obs_fin[i] = bus.final_pred_target[i];
`ifdef FETCH_PC_GEN_PERF_EN
    obs_stalls    = bus.perf_stalls;
    obs_redirects = bus.perf_redirects;
`endif

    if (chk_en) begin
      check_eq("fetch_valid", 64'(obs_fv), 64'(m_valid));
      check_eq("fetch_pc", 64'(obs_pc), 64'(cur_pc));
      check_eq("slot_valid", 64'(obs_sv), 64'(sv));
      check_eq("taken_valid", 64'(obs_tv), 64'(tv));
      check_eq("taken_slot", 64'(obs_ts), 64'(ts));
      for (int i = 0; i < FW; i++) check_eq("final_pred_target", 64'(obs_fin[i]), 64'(fin[i]));
`ifdef FETCH_PC_GEN_PERF_EN
      check_eq("perf_redirects", 64'(bus.perf_redirects), m_perf_r);
      check_eq("perf_stalls", 64'(bus.perf_stalls), m_perf_s);
      check_eq("perf_taken", 64'(bus.perf_taken), m_perf_t);
`endif
    end

    fire = m_valid && rdy;
    @(posedge clk);
    if (!rst_n_in) begin
      nxt      = RV;
      m_valid  = 1'b0;
      m_perf_r = 0;
      m_perf_s = 0;
      m_perf_t = 0;
    end else begin
      if (rv)            m_perf_r = sat_inc(m_perf_r);
      if (m_valid && !rdy) m_perf_s = sat_inc(m_perf_s);
      if (fire && tv)    m_perf_t = sat_inc(m_perf_t);
      if (rv)        nxt = rpc;
      else if (fire) nxt = tv ? fin[ts] : 32'(base + FW * IB);
      else           nxt = cur_pc;
      m_valid = 1'b1;
    end
    exp_q.push_back(nxt);
    chk_en = 1'b1;
  endtask

  task automatic redirect_to(input logic [31:0] target);
    idle_inputs();
    rv  = 1'b1;
    rpc = target;
    run_cycle();
    idle_inputs();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    n_checks = 0;
    n_pass   = 0;
    m_valid  = 1'b0;
    m_perf_r = 0;
    m_perf_s = 0;
    m_perf_t = 0;
    chk_en   = 1'b0;
    exp_q.push_back(RV);
    idle_inputs();

    // reset held low for three cycles
    rst_n_in = 1'b0;
    repeat (3) run_cycle();
    check_eq("rst_pc", 64'(obs_pc), 64'h0);
    check_eq("rst_valid", 64'(obs_fv), 64'h0);
    check_eq("rst_slot_valid", 64'(obs_sv), 64'h0);
    check_eq("rst_taken", 64'({obs_tv, obs_ts}), 64'h0);

    // sequential advance from the reset vector
    rst_n_in = 1'b1;
    run_cycle();
    run_cycle();
    check_eq("seq_pc0", 64'(obs_pc), 64'h0);
    check_eq("seq_valid0", 64'(obs_fv), 64'h1);
    check_eq("seq_sv0", 64'(obs_sv), 64'h3);
    run_cycle();
    check_eq("seq_pc1", 64'(obs_pc), 64'h8);
    run_cycle();
    check_eq("seq_pc2", 64'(obs_pc), 64'h10);

    // unaligned redirect
    redirect_to(32'h104);
    run_cycle();
    check_eq("redir_pc", 64'(obs_pc), 64'h104);
    check_eq("redir_sv", 64'(obs_sv), 64'h2);
    run_cycle();
    check_eq("redir_next", 64'(obs_pc), 64'h108);

    // taken branch in slot 0
    redirect_to(32'h40);
    sl[0].btb_hit = 1'b1; sl[0].is_branch = 1'b1; sl[0].pred_taken = 1'b1;
    sl[0].pred_target = 32'h200;
    run_cycle();
    check_eq("br_taken_slot", 64'(obs_ts), 64'h0);
    check_eq("br_taken_valid", 64'(obs_tv), 64'h1);
    check_eq("br_sv", 64'(obs_sv), 64'h1);
    idle_inputs();
    run_cycle();
    check_eq("br_target", 64'(obs_pc), 64'h200);

    // same branch predicted not-taken
    redirect_to(32'h40);
    sl[0].btb_hit = 1'b1; sl[0].is_branch = 1'b1; sl[0].pred_taken = 1'b0;
    sl[0].pred_target = 32'h200;
    run_cycle();
    check_eq("nt_taken_valid", 64'(obs_tv), 64'h0);
    check_eq("nt_sv", 64'(obs_sv), 64'h3);
    // return in slot 1 takes the RAS address
    sl[0] = '0;
    sl[1].btb_hit = 1'b1; sl[1].is_ret = 1'b1;
    sl[1].ret_addr = 32'h300; sl[1].pred_target = 32'h999;
    run_cycle();
    check_eq("nt_next", 64'(obs_pc), 64'h48);
    check_eq("ret_final", 64'(obs_fin[1]), 64'h300);
    check_eq("ret_slot", 64'(obs_ts), 64'h1);
    idle_inputs();
    run_cycle();
    check_eq("ret_target", 64'(obs_pc), 64'h300);

    // stall window with a redirect in its second cycle
    rst_n_in = 1'b0;
    run_cycle();
    rst_n_in = 1'b1;
    run_cycle();
    redirect_to(32'h80);
    rdy = 1'b0;
    run_cycle();
    check_eq("stall_hold0", 64'(obs_pc), 64'h80);
    rv = 1'b1; rpc = 32'h500;
    run_cycle();
    check_eq("stall_hold1", 64'(obs_pc), 64'h80);
    rv = 1'b0;
    run_cycle();
    check_eq("stall_redir_pc", 64'(obs_pc), 64'h500);
    check_eq("stall_redir_valid", 64'(obs_fv), 64'h1);
`ifdef FETCH_PC_GEN_PERF_EN
    check_eq("stall_perf", 64'(obs_stalls), 64'h2);
    check_eq("stall_perf_redir", 64'(obs_redirects), 64'h2);
`endif
    run_cycle();
    check_eq("stall_hold2", 64'(obs_pc), 64'h500);
    idle_inputs();

    // address wrap at the top of the space
    redirect_to(32'hFFFF_FFF8);
    run_cycle();
    check_eq("wrap_pc", 64'(obs_pc), 64'hFFFF_FFF8);
    run_cycle();
    check_eq("wrap_next", 64'(obs_pc), 64'h0);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      rst_n_in = ($urandom_range(0, 99) != 0);
      rv       = ($urandom_range(0, 9) == 0);
      rpc      = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC))
                                             : ($urandom & 32'h0000_FFFC);
      rdy      = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < FW; i++) begin
        sl[i].btb_hit     = $urandom_range(0, 1);
        sl[i].is_branch   = ($urandom_range(0, 3) != 0);
        sl[i].is_ret      = ($urandom_range(0, 5) == 0);
        sl[i].pred_taken  = $urandom_range(0, 1);
        sl[i].pred_target = $urandom & 32'h0000_FFFC;
        sl[i].ret_addr    = ($urandom_range(0, 1) != 0) ? ($urandom & 32'h0000_FFFC) : $urandom;
      end
      run_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
